// File: rtl/matmul_engine_if.sv
// Host-side bundle for matmul_engine: operand load port, start/status, result stream and result read port.
// AW is derived from N so host and engine always agree on element address width.
interface matmul_engine_if #(
  parameter int N  = 3,
  parameter int DW = 16
);
  localparam int AW = $clog2(N*N);

  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          res_valid;
  logic [AW-1:0] res_idx;
  logic [DW-1:0] res_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          ovf;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    input  busy, done, res_valid, res_idx, res_data, rd_data, ovf
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
    output busy, done, res_valid, res_idx, res_data, rd_data, ovf
  );
endinterface

// File: rtl/matmul_engine.sv
// N x N unsigned matrix multiply: read -> multiply -> accumulate, one product per cycle, results streamed and stored.
// Optional MATMUL_SAT_EN clamps overflowing elements to all-ones instead of keeping the low DW bits.
module matmul_engine #(
  parameter int N  = 3,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  matmul_engine_if.slave  bus
);
  localparam int AW   = $clog2(N*N);
  localparam int NN   = N*N;
  localparam int CW   = $clog2(N);
  localparam int ACCW = 2*DW + $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_i, r_j, r_k;
  logic [DW-1:0]   r_mem_a [NN];
  logic [DW-1:0]   r_mem_b [NN];
  logic [DW-1:0]   r_mem_r [NN];
  logic [DW-1:0]   r_a_q, r_b_q;
  logic [2*DW-1:0] r_prod;
  logic [ACCW-1:0] r_acc;
  logic            r_v0, r_v1, r_first0, r_first1, r_last0, r_last1;
  logic [AW-1:0]   r_idx0, r_idx1;
  logic            r_busy, r_done, r_res_valid, r_ovf;
  logic [AW-1:0]   r_res_idx;
  logic [DW-1:0]   r_res_data, r_rd_data;

  logic            w_issue, w_k_last, w_j_last, w_i_last, w_big, w_res_wr;
  logic [AW-1:0]   w_a_addr, w_b_addr, w_c_idx;
  logic [ACCW-1:0] w_sum;
  logic [DW-1:0]   w_res;

  assign w_issue  = (r_state == RUN);
  assign w_k_last = (r_k == CW'(N-1));
  assign w_j_last = (r_j == CW'(N-1));
  assign w_i_last = (r_i == CW'(N-1));
  assign w_a_addr = AW'(r_i) * AW'(N) + AW'(r_k);
  assign w_b_addr = AW'(r_k) * AW'(N) + AW'(r_j);
  assign w_c_idx  = AW'(r_i) * AW'(N) + AW'(r_j);

  // k == 0 restarts the sum; the accumulator is wide enough that no carry is ever dropped
  assign w_sum    = (r_first1 ? '0 : r_acc) + ACCW'(r_prod);
  assign w_big    = |w_sum[ACCW-1:DW];
  assign w_res_wr = r_v1 && r_last1;

`ifdef MATMUL_SAT_EN
  assign w_res = w_big ? {DW{1'b1}} : w_sum[DW-1:0];
`else
  assign w_res = w_sum[DW-1:0];
`endif

  // Datapath and storage: arrays and pipeline data are never reset
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.wr_en) begin
      if (bus.wr_sel) r_mem_b[bus.wr_addr] <= bus.wr_data;
      else            r_mem_a[bus.wr_addr] <= bus.wr_data;
    end
    if (w_issue) begin
      r_a_q <= r_mem_a[w_a_addr];
      r_b_q <= r_mem_b[w_b_addr];
    end
    r_prod <= (2*DW)'(r_a_q) * (2*DW)'(r_b_q);
    if (r_v1) r_acc <= w_sum;
    if (w_res_wr && !rst) r_mem_r[r_idx1] <= w_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_first0    <= 1'b0;
      r_first1    <= 1'b0;
      r_last0     <= 1'b0;
      r_last1     <= 1'b0;
      r_idx0      <= '0;
      r_idx1      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_res_data  <= '0;
      r_ovf       <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_done      <= 1'b0;
      r_res_valid <= 1'b0;
      r_rd_data   <= r_mem_r[bus.rd_addr];

      r_v0     <= w_issue;
      r_first0 <= (r_k == '0);
      r_last0  <= w_k_last;
      r_idx0   <= w_c_idx;
      r_v1     <= r_v0;
      r_first1 <= r_first0;
      r_last1  <= r_last0;
      r_idx1   <= r_idx0;

      if (w_res_wr) begin
        r_res_valid <= 1'b1;
        r_res_idx   <= r_idx1;
        r_res_data  <= w_res;
        if (w_big) r_ovf <= 1'b1;
      end

      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
          r_ovf   <= 1'b0;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
        end
        RUN: begin
          if (w_k_last) begin
            r_k <= '0;
            if (w_j_last) begin
              r_j <= '0;
              if (w_i_last) begin
                r_i     <= '0;
                r_state <= DRAIN;
              end else begin
                r_i <= r_i + 1'b1;
              end
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DRAIN: if (!r_v0 && !r_v1) begin
          r_state <= FIN;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.res_valid = r_res_valid;
  assign bus.res_idx   = r_res_idx;
  assign bus.res_data  = r_res_data;
  assign bus.rd_data   = r_rd_data;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine: N=3/DW=16 and N=4/DW=8 instances, hand-computed results and cycle positions.
// Honours MATMUL_SAT_EN for the expected overflow element value.
module tb_matmul_engine;
  logic clk;
  logic rst;

  matmul_engine_if #(.N(3), .DW(16)) if3 ();
  matmul_engine_if #(.N(4), .DW(8))  if4 ();

  matmul_engine #(.N(3), .DW(16)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  matmul_engine #(.N(4), .DW(8))  dut4 (.clk(clk), .rst(rst), .bus(if4));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  localparam int EXP_BASE [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
`ifdef MATMUL_SAT_EN
  localparam int EXP_OVF = 32'hFFFF;
`else
  localparam int EXP_OVF = 32'h0003;
`endif

  int m_nres, m_ndone, m_done_rel, m_busy1, m_busy_done, m_ovf1, m_busy_after;
  int m_rel [40];
  int m_idx [40];
  int m_dat [40];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr3(input logic sel, input int addr, input int data);
    if3.wr_en   = 1'b1;
    if3.wr_sel  = sel;
    if3.wr_addr = 4'(addr);
    if3.wr_data = 16'(data);
    tick();
    if3.wr_en = 1'b0;
  endtask

  task automatic wr4(input logic sel, input int addr, input int data);
    if4.wr_en   = 1'b1;
    if4.wr_sel  = sel;
    if4.wr_addr = 4'(addr);
    if4.wr_data = 8'(data);
    tick();
    if4.wr_en = 1'b0;
  endtask

  task automatic clear_mon();
    m_nres = 0; m_ndone = 0; m_done_rel = -1;
    m_busy1 = -1; m_busy_done = -1; m_ovf1 = -1; m_busy_after = -1;
  endtask

  // rel counts cycles after the edge that sampled start; abuse/rst_at pick the cycle to inject
  task automatic run3(input int abuse, input int rst_at, input int budget);
    clear_mon();
    if3.start = 1'b1;
    tick();
    if3.start = 1'b0;
    for (int rel = 1; rel <= budget; rel++) begin
      if (rel == 1) begin m_busy1 = int'(if3.busy); m_ovf1 = int'(if3.ovf); end
      if (rel == rst_at + 1) m_busy_after = int'(if3.busy);
      if (if3.res_valid) begin
        if (m_nres < 40) begin
          m_rel[m_nres] = rel; m_idx[m_nres] = int'(if3.res_idx); m_dat[m_nres] = int'(if3.res_data);
        end
        m_nres++;
      end
      if (if3.done) begin m_ndone++; m_done_rel = rel; m_busy_done = int'(if3.busy); end
      if (rel == abuse) begin
        if3.wr_en = 1'b1; if3.wr_sel = 1'b0; if3.wr_addr = '0; if3.wr_data = 16'd100;
        if3.start = 1'b1;
      end
      if (rel == rst_at) rst = 1'b1;
      tick();
      if3.wr_en = 1'b0; if3.start = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic run4(input int b2b, input int budget);
    clear_mon();
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    for (int rel = 1; rel <= budget; rel++) begin
      if (rel == b2b + 1) m_busy_after = int'(if4.busy);
      if (if4.res_valid) begin
        if (m_nres < 40) begin
          m_rel[m_nres] = rel; m_idx[m_nres] = int'(if4.res_idx); m_dat[m_nres] = int'(if4.res_data);
        end
        m_nres++;
      end
      if (if4.done) begin
        m_ndone++;
        if (m_ndone == 1) m_done_rel = rel; else m_busy_done = rel;
      end
      if (rel == b2b) if4.start = 1'b1;
      tick();
      if4.start = 1'b0;
    end
  endtask

  task automatic check_base(input string p);
    chk({p, "_busy_T1"}, m_busy1, 1);
    chk({p, "_nres"}, m_nres, 9);
    for (int e = 0; e < 9; e++) begin
      chk($sformatf("%s_rel%0d", p, e), m_rel[e], 3*(e+1) + 3);
      chk($sformatf("%s_idx%0d", p, e), m_idx[e], e);
      chk($sformatf("%s_dat%0d", p, e), m_dat[e], EXP_BASE[e]);
    end
    chk({p, "_ndone"}, m_ndone, 1);
    chk({p, "_done_rel"}, m_done_rel, 31);
    chk({p, "_busy_at_done"}, m_busy_done, 0);
    chk({p, "_ovf"}, if3.ovf, 0);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    if3.wr_en = 0; if3.wr_sel = 0; if3.wr_addr = '0; if3.wr_data = '0; if3.start = 0; if3.rd_addr = '0;
    if4.wr_en = 0; if4.wr_sel = 0; if4.wr_addr = '0; if4.wr_data = '0; if4.start = 0; if4.rd_addr = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy", if3.busy, 0);
    chk("rst_done", if3.done, 0);
    chk("rst_res_valid", if3.res_valid, 0);
    chk("rst_ovf", if3.ovf, 0);
    chk("rst_res_idx", if3.res_idx, 0);
    chk("rst_res_data", if3.res_data, 0);
    chk("rst_rd_data", if3.rd_data, 0);
    chk("rst_busy4", if4.busy, 0);

    for (int a = 0; a < 9; a++) begin
      wr3(1'b0, a, a + 1);
      wr3(1'b1, a, 9 - a);
    end
    run3(0, 0, 40);
    check_base("base");

    if3.rd_addr = 4'd4;
    tick();
    chk("rd_addr4", if3.rd_data, 69);
    if3.rd_addr = 4'd8;
    tick();
    chk("rd_addr8", if3.rd_data, 90);

    run3(5, 0, 40);
    check_base("abuse");

    run3(0, 10, 40);
    chk("midrst_busy", m_busy_after, 0);
    chk("midrst_ndone", m_ndone, 0);
    chk("midrst_nres", m_nres, 2);

    run3(0, 0, 40);
    check_base("restart");
    if3.rd_addr = 4'd0;
    tick();
    chk("restart_rd0", if3.rd_data, 30);

    for (int a = 0; a < 9; a++) begin
      wr3(1'b0, a, 16'hFFFF);
      wr3(1'b1, a, 16'hFFFF);
    end
    run3(0, 0, 40);
    chk("ovf_nres", m_nres, 9);
    for (int e = 0; e < 9; e++) chk($sformatf("ovf_dat%0d", e), m_dat[e], EXP_OVF);
    chk("ovf_flag", if3.ovf, 1);
    chk("ovf_done_rel", m_done_rel, 31);

    for (int a = 0; a < 9; a++) begin
      wr3(1'b0, a, 1);
      wr3(1'b1, a, 1);
    end
    run3(0, 0, 40);
    chk("ones_ovf_T1", m_ovf1, 0);
    chk("ones_ovf_end", if3.ovf, 0);
    for (int e = 0; e < 9; e++) chk($sformatf("ones_dat%0d", e), m_dat[e], 3);

    for (int a = 0; a < 16; a++) begin
      wr4(1'b0, a, (a / 4 == a % 4) ? 1 : 0);
      wr4(1'b1, a, a);
    end
    run4(69, 150);
    chk("n4_nres", m_nres, 32);
    for (int e = 0; e < 16; e++) begin
      chk($sformatf("n4_rel%0d", e), m_rel[e], 4*(e+1) + 3);
      chk($sformatf("n4_dat%0d", e), m_dat[e], e);
      chk($sformatf("n4b_dat%0d", e), m_dat[e+16], e);
    end
    chk("n4_done_rel", m_done_rel, 68);
    chk("n4_b2b_busy", m_busy_after, 1);
    chk("n4_ndone", m_ndone, 2);
    chk("n4_done2_rel", m_busy_done, 137);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
